simmem_delay_releaser: RTL and testbench
========================================

Name: simmem_delay_releaser

Overview:
- Parametrised per-channel latency enforcer for the simulated memory controller.
- Tracks every accepted address request per channel in an in-order slot table with a countdown of a runtime-programmable delay.
- Holds back the matching response (single or multi-beat) until that delay has elapsed.
- Sits between the request/response handshakes and the message banks; generalises the fixed two-channel release logic to N channels with burst awareness and per-channel runtime delays.

Parameters:
- NumChannels, 2, number of independent request/response channel pairs (index 0 = read, 1 = write by convention).
- Capacity, 16, outstanding requests trackable per channel (>=2, any integer).
- CounterWidth, 8, width of each delay countdown and of delay_i fields.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous reset, active-high
- delay_i  in  NumChannels*CounterWidth  per-channel delay; channel c at [c*CounterWidth +: CounterWidth]
- req_valid_i  in  NumChannels  upstream request valid
- req_ready_o  out  NumChannels  ready to upstream
- req_valid_o  out  NumChannels  valid to memory
- req_ready_i  in  NumChannels  memory ready
- resp_valid_i  in  NumChannels  memory response valid
- resp_last_i  in  NumChannels  last beat of response burst
- resp_ready_o  out  NumChannels  ready to memory
- resp_valid_o  out  NumChannels  response valid downstream
- resp_ready_i  in  NumChannels  downstream ready
- unexpected_resp_o  out  NumChannels  sticky: response presented while table empty

Behaviour:
- Channels fully independent; all rules below are per channel c.
- full = (count == Capacity); empty = (count == 0); count is registered; no same-cycle bypass.
- Request path, combinational: req_valid_o = req_valid_i & ~full; req_ready_o = req_ready_i & ~full.
- Allocation on req_valid_i & req_ready_o:
  - write delay_i[c] into the slot at the tail pointer; tail advances with explicit wrap at Capacity-1.
  - count increments.
- Countdown:
  - every occupied slot decrements by 1 each cycle after its allocation cycle; saturates at 0.
  - slot is mature when its value is 0.
  - delay D: head becomes mature D cycles after the allocation cycle.
  - earliest response handshake is cycle alloc+max(D,1); D=0 gives the next cycle.
- Response path, combinational:
  - head_ok = ~empty & head mature.
  - resp_valid_o = resp_valid_i & head_ok; resp_ready_o = resp_ready_i & head_ok.
- Release:
  - beats handshake while head_ok; only a beat with resp_last_i frees the head.
  - on free, the head pointer wraps and count decrements.
  - non-last beats never alter state.
- Simultaneous allocate and free: both take effect; count unchanged; pointers both advance.
- When full, a free in the same cycle does not unblock requests until the next cycle.
- Response while empty:
  - stalled (resp_ready_o=0).
  - unexpected_resp_o[c] sets and stays set until reset.
- delay_i changes affect only slots allocated after the change.
- Reset (any cycle, including mid-burst):
  - count=0, pointers=0, all countdowns=0, unexpected_resp_o=0.
  - outstanding slots are discarded.
  - after reset: req_ready_o=req_ready_i, resp_ready_o=0, resp_valid_o=0.

Optional Feature:
- Macro SIMMEM_DELAY_RELEASER_STATS_EN.
- Defined:
  - adds outputs outstanding_o (NumChannels*($clog2(Capacity+1))) carrying the live count.
  - adds stall_cycles_o (NumChannels*32), a saturating count of cycles with resp_valid_i & ~head_ok & ~empty.
  - both cleared on reset.
- Undefined: these ports and their logic are absent; all other behaviour is identical.

Decomposition:
- simmem_pkg gains:
  - localparam SimmemDefaultDelayWidth = 8.
  - typedef delay_cnt_t (logic [CounterWidth-1:0]) via package parameter.
  - a helper function for the wrap-increment of slot pointers.
- Sub-module simmem_delay_slot_fifo holds one channel's slot table, pointers, countdowns and flags.
- Top generates NumChannels instances and slices the vectors.

Test Plan:
- Delay 5, ch0: request handshake at cycle 10, memory response valid from cycle 11 with last=1 -> resp_valid_o first high cycle 15; handshake at 15; count back to 0.
- Delay 0, ch1: request at cycle 3, response waiting -> released at cycle 4.
- Capacity=4, 4 requests accepted, ready held -> req_ready_o=0 on 5th; free at cycle t -> 5th accepted at t+1, not t.
- Burst of 4 beats (last on 4th), delay 2 -> beats 1-3 pass without freeing; head freed only on beat 4; second request's head then governs.
- Different delays, ch0=20 and ch1=3, requests in the same cycle -> ch1 releases 17 cycles before ch0; no cross-channel blocking.
- Response with empty table -> stalled, unexpected_resp_o=1 sticky; rst_i asserted mid-burst with 3 outstanding -> next cycle count=0, flag cleared, resp_valid_o=0.

Source files
------------

// File: rtl/simmem_pkg.sv
// ============================================================================
// Module      : simmem_pkg
// Description : Shared types, constants and helpers for the simulated memory
//               controller delay releaser.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package simmem_pkg;

    // Default width of a per-channel delay and of each slot countdown
    localparam int SimmemDefaultDelayWidth = 8;

    // Package-level counter width used for the shared delay type
    localparam int SimmemCounterWidth = SimmemDefaultDelayWidth;

    typedef logic [SimmemCounterWidth-1:0] delay_cnt_t;

    // Slot pointer increment with explicit wrap at cap-1 (cap need not be 2^n)
    function automatic int simmem_ptr_wrap_inc(input int ptr, input int cap);
        return (ptr == cap - 1) ? 0 : ptr + 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/simmem_delay_releaser_if.sv
// ============================================================================
// Module      : simmem_delay_releaser_if
// Description : Per-channel request/response handshake bundle between the
//               upstream requester, the delay releaser and the memory banks.
//               Signal suffixes are from the releaser's point of view.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface simmem_delay_releaser_if #(
    parameter int NumChannels = 2
);
    logic [NumChannels-1:0] req_valid_i;
    logic [NumChannels-1:0] req_ready_o;
    logic [NumChannels-1:0] req_valid_o;
    logic [NumChannels-1:0] req_ready_i;
    logic [NumChannels-1:0] resp_valid_i;
    logic [NumChannels-1:0] resp_last_i;
    logic [NumChannels-1:0] resp_ready_o;
    logic [NumChannels-1:0] resp_valid_o;
    logic [NumChannels-1:0] resp_ready_i;

    // Releaser side
    modport slave (
        input  req_valid_i, req_ready_i, resp_valid_i, resp_last_i, resp_ready_i,
        output req_ready_o, req_valid_o, resp_ready_o, resp_valid_o
    );

    // Environment side (requester + memory + response consumer)
    modport master (
        output req_valid_i, req_ready_i, resp_valid_i, resp_last_i, resp_ready_i,
        input  req_ready_o, req_valid_o, resp_ready_o, resp_valid_o
    );
endinterface

`default_nettype wire

// File: rtl/simmem_delay_slot_fifo.sv
// ============================================================================
// Module      : simmem_delay_slot_fifo
// Description : One channel of the delay releaser: in-order slot table with a
//               countdown per outstanding request. The head response is
//               released only once its countdown has reached zero; only the
//               last beat of a burst frees the head slot.
//               Optional statistics: SIMMEM_DELAY_RELEASER_STATS_EN
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module simmem_delay_slot_fifo
    import simmem_pkg::*;
#(
    parameter  int Capacity     = 16,
    parameter  int CounterWidth = SimmemDefaultDelayWidth,
    localparam int PTR_W        = $clog2(Capacity),
    localparam int CNT_W        = $clog2(Capacity + 1)
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic [CounterWidth-1:0] delay_i,
    input  logic                    req_valid_i,
    input  logic                    req_ready_i,
    output logic                    req_valid_o,
    output logic                    req_ready_o,
    input  logic                    resp_valid_i,
    input  logic                    resp_last_i,
    input  logic                    resp_ready_i,
    output logic                    resp_valid_o,
    output logic                    resp_ready_o,
    output logic                    unexpected_resp_o
`ifdef SIMMEM_DELAY_RELEASER_STATS_EN
    ,
    output logic [CNT_W-1:0]        outstanding_o,
    output logic [31:0]             stall_cycles_o
`endif
);

    logic [CounterWidth-1:0] slot_q [Capacity];
    logic [CounterWidth-1:0] slot_d [Capacity];
    logic [PTR_W-1:0]        head_q, head_d;
    logic [PTR_W-1:0]        tail_q, tail_d;
    logic [CNT_W-1:0]        count_q, count_d;
    logic                    unexpected_q, unexpected_d;

    logic                    full;
    logic                    empty;
    logic                    head_ok;
    logic                    alloc;
    logic                    release_head;
    logic [CounterWidth-1:0] alloc_value;

    assign full    = (count_q == CNT_W'(Capacity));
    assign empty   = (count_q == '0);
    assign head_ok = ~empty & (slot_q[head_q] == '0);

    assign req_valid_o  = req_valid_i & ~full;
    assign req_ready_o  = req_ready_i & ~full;
    assign resp_valid_o = resp_valid_i & head_ok;
    assign resp_ready_o = resp_ready_i & head_ok;

    assign alloc        = req_valid_i & req_ready_o;
    assign release_head = resp_valid_i & resp_ready_o & resp_last_i;

    // The slot holds D-1 on the first cycle after allocation, so it reaches
    // zero D cycles after the allocation cycle; D=0 is treated like D=1.
    assign alloc_value = (delay_i == '0) ? '0 : delay_i - CounterWidth'(1);

    assign unexpected_resp_o = unexpected_q;

    // Next-state: countdowns, pointers, occupancy and the sticky flag
    always_comb begin
        for (int i = 0; i < Capacity; i++) begin
            slot_d[i] = (slot_q[i] == '0) ? '0 : slot_q[i] - CounterWidth'(1);
        end
        if (alloc) begin
            slot_d[tail_q] = alloc_value;
        end

        tail_d = alloc ? PTR_W'(simmem_ptr_wrap_inc(int'(tail_q), Capacity)) : tail_q;
        head_d = release_head ? PTR_W'(simmem_ptr_wrap_inc(int'(head_q), Capacity)) : head_q;

        count_d = count_q;
        case ({alloc, release_head})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase

        unexpected_d = unexpected_q | (resp_valid_i & empty);
    end

    // State registers with synchronous reset discarding all outstanding slots
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < Capacity; i++) begin
                slot_q[i] <= '0;
            end
            head_q       <= '0;
            tail_q       <= '0;
            count_q      <= '0;
            unexpected_q <= 1'b0;
        end else begin
            for (int i = 0; i < Capacity; i++) begin
                slot_q[i] <= slot_d[i];
            end
            head_q       <= head_d;
            tail_q       <= tail_d;
            count_q      <= count_d;
            unexpected_q <= unexpected_d;
        end
    end

`ifdef SIMMEM_DELAY_RELEASER_STATS_EN
    logic [31:0] stall_q, stall_d;

    assign outstanding_o  = count_q;
    assign stall_cycles_o = stall_q;

    // Saturating count of cycles where a response waits on an immature head
    always_comb begin
        stall_d = stall_q;
        if (resp_valid_i & ~head_ok & ~empty & (stall_q != '1)) begin
            stall_d = stall_q + 32'd1;
        end
    end

    // Stall counter register
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            stall_q <= '0;
        end else begin
            stall_q <= stall_d;
        end
    end
`endif

endmodule

`default_nettype wire

// File: rtl/simmem_delay_releaser.sv
// ============================================================================
// Module      : simmem_delay_releaser
// Description : N-channel latency enforcer for the simulated memory
//               controller. Each channel independently delays its responses
//               by a runtime-programmable number of cycles after the request.
//               Optional statistics: SIMMEM_DELAY_RELEASER_STATS_EN
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module simmem_delay_releaser
    import simmem_pkg::*;
#(
    parameter  int NumChannels  = 2,
    parameter  int Capacity     = 16,
    parameter  int CounterWidth = SimmemDefaultDelayWidth,
    localparam int CNT_W        = $clog2(Capacity + 1)
) (
    input  logic                                clk_i,
    input  logic                                rst_i,
    input  logic [NumChannels*CounterWidth-1:0] delay_i,
    simmem_delay_releaser_if.slave              bus,
    output logic [NumChannels-1:0]              unexpected_resp_o
`ifdef SIMMEM_DELAY_RELEASER_STATS_EN
    ,
    output logic [NumChannels*CNT_W-1:0]        outstanding_o,
    output logic [NumChannels*32-1:0]           stall_cycles_o
`endif
);

    for (genvar c = 0; c < NumChannels; c++) begin : g_chan
        simmem_delay_slot_fifo #(
            .Capacity     (Capacity),
            .CounterWidth (CounterWidth)
        ) u_fifo (
            .clk_i             (clk_i),
            .rst_i             (rst_i),
            .delay_i           (delay_i[c*CounterWidth +: CounterWidth]),
            .req_valid_i       (bus.req_valid_i[c]),
            .req_ready_i       (bus.req_ready_i[c]),
            .req_valid_o       (bus.req_valid_o[c]),
            .req_ready_o       (bus.req_ready_o[c]),
            .resp_valid_i      (bus.resp_valid_i[c]),
            .resp_last_i       (bus.resp_last_i[c]),
            .resp_ready_i      (bus.resp_ready_i[c]),
            .resp_valid_o      (bus.resp_valid_o[c]),
            .resp_ready_o      (bus.resp_ready_o[c]),
            .unexpected_resp_o (unexpected_resp_o[c])
`ifdef SIMMEM_DELAY_RELEASER_STATS_EN
            ,
            .outstanding_o     (outstanding_o[c*CNT_W +: CNT_W]),
            .stall_cycles_o    (stall_cycles_o[c*32 +: 32])
`endif
        );
    end

endmodule

`default_nettype wire

// File: tb/tb_simmem_delay_releaser.sv
// ============================================================================
// Module      : tb_simmem_delay_releaser
// Description : Self-checking bench for simmem_delay_releaser. A timestamp
//               scoreboard per channel predicts when each head may be
//               released; directed scenarios check latencies and boundaries.
//               Optional statistics: SIMMEM_DELAY_RELEASER_STATS_EN
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_simmem_delay_releaser;
    import simmem_pkg::*;

    localparam int NCH   = 2;
    localparam int CAP   = 4;
    localparam int CW    = SimmemDefaultDelayWidth;
    localparam int CNT_W = $clog2(CAP + 1);

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [NCH*CW-1:0] delay;
    logic [NCH-1:0]    unexp;
`ifdef SIMMEM_DELAY_RELEASER_STATS_EN
    logic [NCH*CNT_W-1:0] outst;
    logic [NCH*32-1:0]    stall;
`endif

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    simmem_delay_releaser_if #(.NumChannels(NCH)) bus ();

    simmem_delay_releaser #(
        .NumChannels  (NCH),
        .Capacity     (CAP),
        .CounterWidth (CW)
    ) dut (
        .clk_i             (clk),
        .rst_i             (rst),
        .delay_i           (delay),
        .bus               (bus),
        .unexpected_resp_o (unexp)
`ifdef SIMMEM_DELAY_RELEASER_STATS_EN
        ,
        .outstanding_o     (outst),
        .stall_cycles_o    (stall)
`endif
    );

    task automatic tb_check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // ---------------- scoreboard: earliest release cycle per outstanding request
    int   exp_q [NCH][$];
    logic m_unexp [NCH];
    int unsigned m_stall [NCH];

    initial begin
        for (int c = 0; c < NCH; c++) begin
            m_unexp[c] = 1'b0;
            m_stall[c] = 0;
        end
    end

    always @(negedge clk) begin
        bit full_m, empty_m, ok_m, alloc_m, rel_o;
        int d, popped;
        for (int c = 0; c < NCH; c++) begin
            full_m  = (exp_q[c].size() == CAP);
            empty_m = (exp_q[c].size() == 0);
            ok_m    = !empty_m && (cyc >= exp_q[c][0]);

            tb_check($sformatf("req_ready_o[%0d]", c), 32'(bus.req_ready_o[c]), 32'(bus.req_ready_i[c] & !full_m));
            tb_check($sformatf("req_valid_o[%0d]", c), 32'(bus.req_valid_o[c]), 32'(bus.req_valid_i[c] & !full_m));
            tb_check($sformatf("resp_valid_o[%0d]", c), 32'(bus.resp_valid_o[c]), 32'(bus.resp_valid_i[c] & ok_m));
            tb_check($sformatf("resp_ready_o[%0d]", c), 32'(bus.resp_ready_o[c]), 32'(bus.resp_ready_i[c] & ok_m));
            tb_check($sformatf("unexpected_resp_o[%0d]", c), 32'(unexp[c]), 32'(m_unexp[c]));
`ifdef SIMMEM_DELAY_RELEASER_STATS_EN
            tb_check($sformatf("outstanding_o[%0d]", c), 32'(outst[c*CNT_W +: CNT_W]), 32'(exp_q[c].size()));
            tb_check($sformatf("stall_cycles_o[%0d]", c), stall[c*32 +: 32], m_stall[c]);
`endif
            alloc_m = bus.req_valid_i[c] & bus.req_ready_i[c] & !full_m;
            rel_o   = bus.resp_valid_o[c] & bus.resp_ready_i[c] & bus.resp_last_i[c];
            d       = int'(delay[c*CW +: CW]);

            if (rst) begin
                exp_q[c].delete();
                m_unexp[c] = 1'b0;
                m_stall[c] = 0;
            end else begin
                if (rel_o) begin
                    if (empty_m) begin
                        tb_check($sformatf("release_without_request[%0d]", c), 1, 0);
                    end else begin
                        popped = exp_q[c].pop_front();
                        tb_check($sformatf("release_mature[%0d]", c), 32'(cyc >= popped), 1);
                    end
                end
                if (alloc_m) exp_q[c].push_back(cyc + ((d == 0) ? 1 : d));
                if (bus.resp_valid_i[c] & empty_m) m_unexp[c] = 1'b1;
                if (bus.resp_valid_i[c] & !ok_m & !empty_m & (m_stall[c] != 32'hffff_ffff)) m_stall[c]++;
            end
        end
    end

    // ---------------- stimulus helpers
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Wait for a response handshake on channel c; returns at the negedge it is seen
    task automatic wait_hs(input int c, input string tag, output int got);
        got = -1;
        for (int k = 0; k < 60; k++) begin
            @(negedge clk);
            if (bus.resp_valid_o[c] && bus.resp_ready_i[c]) begin
                got = cyc;
                break;
            end
            step();
        end
        if (got < 0) tb_check({tag, "_timeout"}, 0, 1);
    endtask

    // Present last-beat responses on channel c until its scoreboard is empty
    task automatic drain(input int c, input string tag);
        bit done;
        done = 1'b0;
        bus.resp_valid_i[c] = 1'b1;
        bus.resp_last_i[c]  = 1'b1;
        for (int k = 0; k < 100; k++) begin
            if (exp_q[c].size() == 0) begin
                done = 1'b1;
                break;
            end
            step();
        end
        bus.resp_valid_i[c] = 1'b0;
        bus.resp_last_i[c]  = 1'b0;
        tb_check({tag, "_drained"}, 32'(done), 1);
    endtask

    // ---------------- directed scenarios
    initial begin
        int a, g0, g1;
        bus.req_valid_i  = '0;
        bus.req_ready_i  = '1;
        bus.resp_valid_i = '0;
        bus.resp_last_i  = '0;
        bus.resp_ready_i = '1;
        delay            = '0;
        rst              = 1'b1;
        repeat (3) step();
        rst = 1'b0;

        @(negedge clk);
        tb_check("rst_req_ready", 32'(bus.req_ready_o), 32'(bus.req_ready_i));
        tb_check("rst_resp_valid", 32'(bus.resp_valid_o), 0);
        step();

        // Delay 5 on channel 0, single-beat response waiting from the next cycle
        delay[0*CW +: CW] = 8'd5;
        bus.req_valid_i[0] = 1'b1;
        a = cyc;
        step();
        bus.req_valid_i[0]  = 1'b0;
        bus.resp_valid_i[0] = 1'b1;
        bus.resp_last_i[0]  = 1'b1;
        wait_hs(0, "t1", g0);
        tb_check("t1_latency_d5", 32'(g0 - a), 5);
        step();
        bus.resp_valid_i[0] = 1'b0;
        bus.resp_last_i[0]  = 1'b0;
        step();

        // Delay 0 on channel 1 releases on the cycle after the request
        delay[1*CW +: CW] = 8'd0;
        bus.req_valid_i[1] = 1'b1;
        a = cyc;
        step();
        bus.req_valid_i[1]  = 1'b0;
        bus.resp_valid_i[1] = 1'b1;
        bus.resp_last_i[1]  = 1'b1;
        wait_hs(1, "t2", g1);
        tb_check("t2_latency_d0", 32'(g1 - a), 1);
        step();
        bus.resp_valid_i[1] = 1'b0;
        bus.resp_last_i[1]  = 1'b0;
        step();

        // Fill channel 0, free in the full cycle, fifth request accepted one cycle later
        delay[0*CW +: CW] = 8'd3;
        bus.req_valid_i[0] = 1'b1;
        repeat (CAP) step();
        bus.resp_valid_i[0] = 1'b1;
        bus.resp_last_i[0]  = 1'b1;
        @(negedge clk);
        tb_check("t3_full_ready", 32'(bus.req_ready_o[0]), 0);
        tb_check("t3_free_valid", 32'(bus.resp_valid_o[0]), 1);
        step();
        bus.resp_valid_i[0] = 1'b0;
        bus.resp_last_i[0]  = 1'b0;
        @(negedge clk);
        tb_check("t3_ready_after_free", 32'(bus.req_ready_o[0]), 1);
        step();
        bus.req_valid_i[0] = 1'b0;
        drain(0, "t3");
        step();

        // Four-beat burst on delay 2; second request (delay 10) governs afterwards
        delay[0*CW +: CW] = 8'd2;
        bus.req_valid_i[0] = 1'b1;
        a = cyc;
        step();
        delay[0*CW +: CW] = 8'd10;
        step();
        bus.req_valid_i[0] = 1'b0;
        delay[0*CW +: CW]  = 8'd1;
        for (int b = 0; b < 4; b++) begin
            bus.resp_valid_i[0] = 1'b1;
            bus.resp_last_i[0]  = (b == 3);
            wait_hs(0, "t4_beat", g0);
            if (b == 0) tb_check("t4_first_beat", 32'(g0 - a), 2);
            if (b == 3) tb_check("t4_last_beat", 32'(g0 - a), 5);
            step();
        end
        bus.resp_last_i[0] = 1'b1;
        wait_hs(0, "t4_second", g0);
        tb_check("t4_second_latency", 32'(g0 - (a + 1)), 10);
        step();
        bus.resp_valid_i[0] = 1'b0;
        bus.resp_last_i[0]  = 1'b0;
        step();

        // Independent channels: delay 20 on ch0, delay 3 on ch1, same-cycle requests
        delay[0*CW +: CW] = 8'd20;
        delay[1*CW +: CW] = 8'd3;
        bus.req_valid_i = '1;
        a = cyc;
        step();
        bus.req_valid_i  = '0;
        bus.resp_valid_i = '1;
        bus.resp_last_i  = '1;
        wait_hs(1, "t5_ch1", g1);
        step();
        bus.resp_valid_i[1] = 1'b0;
        bus.resp_last_i[1]  = 1'b0;
        wait_hs(0, "t5_ch0", g0);
        step();
        bus.resp_valid_i = '0;
        bus.resp_last_i  = '0;
        tb_check("t5_ch1_latency", 32'(g1 - a), 3);
        tb_check("t5_ch0_latency", 32'(g0 - a), 20);
        tb_check("t5_gap", 32'(g0 - g1), 17);
        step();

        // Response with an empty table stalls and sets a sticky flag
        bus.resp_valid_i[1] = 1'b1;
        bus.resp_last_i[1]  = 1'b1;
        @(negedge clk);
        tb_check("t6_empty_stall", 32'(bus.resp_ready_o[1]), 0);
        step();
        bus.resp_valid_i[1] = 1'b0;
        bus.resp_last_i[1]  = 1'b0;
        @(negedge clk);
        tb_check("t6_unexp_set", 32'(unexp[1]), 1);
        repeat (5) step();
        @(negedge clk);
        tb_check("t6_unexp_sticky", 32'(unexp[1]), 1);
        step();

        // Reset mid-burst with three outstanding requests
        delay[0*CW +: CW] = 8'd1;
        bus.req_valid_i[0] = 1'b1;
        repeat (3) step();
        bus.req_valid_i[0]  = 1'b0;
        bus.resp_valid_i[0] = 1'b1;
        bus.resp_last_i[0]  = 1'b0;
        repeat (2) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        bus.resp_valid_i[0] = 1'b0;
        @(negedge clk);
        tb_check("t6_rst_resp_valid", 32'(bus.resp_valid_o[0]), 0);
        tb_check("t6_rst_resp_ready", 32'(bus.resp_ready_o[0]), 0);
        tb_check("t6_rst_req_ready", 32'(bus.req_ready_o[0]), 1);
        tb_check("t6_rst_unexp", 32'(unexp), 0);
`ifdef SIMMEM_DELAY_RELEASER_STATS_EN
        tb_check("t6_rst_outstanding", 32'(outst[0 +: CNT_W]), 0);
`endif
        repeat (3) step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // Global watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule

`default_nettype wire
